// File: rtl/ctrl_exec_pkg.sv
// rtl/ctrl_exec_pkg.sv - shared types and field layout for the ctrl_exec sequencer
package ctrl_exec_pkg;

    localparam int CTRL_W    = 21;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    localparam int ALU_OP_HI    = 20;
    localparam int ALU_OP_LO    = 19;
    localparam int MEM_SEL_BIT  = 18;
    localparam int MEM_EN_BIT   = 17;
    localparam int MEM_WE_BIT   = 16;
    localparam int VALID_OP_BIT = 15;
    localparam int SRC_A_HI     = 14;
    localparam int SRC_A_LO     = 10;
    localparam int SRC_B_HI     = 9;
    localparam int SRC_B_LO     = 5;
    localparam int DST_HI       = 4;
    localparam int DST_LO       = 0;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2
    } state_e;

    // Packed view of the control word; field order matches the bit positions above.
    typedef struct packed {
        alu_op_e               alu_op;
        logic                  mem_sel;
        logic                  mem_en;
        logic                  mem_we;
        logic                  valid_op;
        logic [REG_IDX_W-1:0]  src_a;
        logic [REG_IDX_W-1:0]  src_b;
        logic [REG_IDX_W-1:0]  dst;
    } ctrl_t;

endpackage

// File: rtl/ctrl_regfile.sv
// rtl/ctrl_regfile.sv - 32-entry register file, two read ports plus debug port, r0 fixed at zero
module ctrl_regfile
    import ctrl_exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] ra_addr_i,
    output logic [DATA_W-1:0]    ra_data_o,
    input  logic [REG_IDX_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0]    rb_data_o,
    input  logic [REG_IDX_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]    dbg_data_o,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = (ra_addr_i  == '0) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o  = (rb_addr_i  == '0) ? '0 : regs_q[rb_addr_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/ctrl_exec.sv
// rtl/ctrl_exec.sv - serial control-word executor with ALU, regfile and dmem handshake; optional watchdog under CTRL_EXEC_TIMEOUT_EN
module ctrl_exec
    import ctrl_exec_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CTRL_W-1:0]    ctrl_i,
    input  logic                 ctrl_valid_i,
    output logic                 ctrl_ready_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [ADDR_W-1:0]    dmem_addr_o,
    output logic [DATA_W-1:0]    dmem_wdata_o,
    input  logic [DATA_W-1:0]    dmem_rdata_i,
    input  logic                 dmem_ack_i,
    output logic                 retire_o,
    output logic                 err_o,
    input  logic [REG_IDX_W-1:0] dbg_raddr_i,
    output logic [DATA_W-1:0]    dbg_rdata_o
);

    state_e               state_q, state_d;
    ctrl_t                ctrl_q;
    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic [ADDR_W-1:0]    dmem_addr_q;
    logic [DATA_W-1:0]    rf_ra_data, rf_rb_data, alu_res, rf_wdata;
    logic [REG_IDX_W-1:0] rf_rb_addr;
    logic                 rf_we;
    logic                 timeout_hit;
    logic                 unused_mem_sel;

    assign unused_mem_sel = ctrl_q.mem_sel;

    // Port B is free once in MEM, so it supplies store data from reg[dst];
    // no register can change while MEM is waiting, which keeps wdata stable.
    assign rf_rb_addr = (state_q == ST_MEM) ? ctrl_q.dst : ctrl_q.src_b;

    ctrl_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra_addr_i  (ctrl_q.src_a),
        .ra_data_o  (rf_ra_data),
        .rb_addr_i  (rf_rb_addr),
        .rb_data_o  (rf_rb_data),
        .dbg_addr_i (dbg_raddr_i),
        .dbg_data_o (dbg_rdata_o),
        .we_i       (rf_we),
        .waddr_i    (ctrl_q.dst),
        .wdata_i    (rf_wdata)
    );

    always_comb begin
        alu_res = '0;
        unique case (ctrl_q.alu_op)
            ALU_AND: alu_res = rf_ra_data & rf_rb_data;
            ALU_OR:  alu_res = rf_ra_data | rf_rb_data;
            ALU_ADD: alu_res = rf_ra_data + rf_rb_data;
            ALU_SUB: alu_res = rf_ra_data - rf_rb_data;
        endcase
    end

`ifdef CTRL_EXEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d       = (state_q == ST_MEM) ? cnt_q + 1'b1 : '0;
    assign timeout_hit = (state_q == ST_MEM) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ctrl_valid_i) state_d = ST_EXEC;
            ST_EXEC: state_d = (ctrl_q.valid_op && ctrl_q.mem_en) ? ST_MEM : ST_IDLE;
            ST_MEM:  if (dmem_ack_i || timeout_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_ready_o = (state_q == ST_IDLE);
        retire_o     = 1'b0;
        err_o        = 1'b0;
        rf_we        = 1'b0;
        rf_wdata     = alu_res;
        unique case (state_q)
            ST_EXEC: begin
                retire_o = !ctrl_q.valid_op || !ctrl_q.mem_en;
                rf_we    = ctrl_q.valid_op && !ctrl_q.mem_en;
            end
            ST_MEM: begin
                retire_o = dmem_ack_i || timeout_hit;
                err_o    = timeout_hit && !dmem_ack_i;
                rf_we    = dmem_ack_i && !dmem_we_q;
                rf_wdata = dmem_rdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && ctrl_valid_i) begin
                ctrl_q <= ctrl_i;
            end
            if ((state_q == ST_EXEC) && ctrl_q.valid_op && ctrl_q.mem_en) begin
                dmem_req_q  <= 1'b1;
                dmem_we_q   <= ctrl_q.mem_we;
                dmem_addr_q <= alu_res[ADDR_W-1:0];
            end else if ((state_q == ST_MEM) && (dmem_ack_i || timeout_hit)) begin
                dmem_req_q <= 1'b0;
            end
        end
    end

    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = ((state_q == ST_MEM) && dmem_we_q) ? rf_rb_data : '0;

endmodule

// File: tb/tb_ctrl_exec.sv
// tb/tb_ctrl_exec.sv - directed plus randomized check of ctrl_exec against a register-array model
module tb_ctrl_exec;

    logic        clk;
    logic        rst_n;
    logic [20:0] ctrl_i;
    logic        ctrl_valid_i;
    logic        ctrl_ready_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        retire_o;
    logic        err_o;
    logic [4:0]  dbg_raddr_i;
    logic [31:0] dbg_rdata_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model [32];

    ctrl_exec #(.DATA_W(32), .ADDR_W(16), .TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_i       (ctrl_i),
        .ctrl_valid_i (ctrl_valid_i),
        .ctrl_ready_o (ctrl_ready_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i),
        .retire_o     (retire_o),
        .err_o        (err_o),
        .dbg_raddr_i  (dbg_raddr_i),
        .dbg_rdata_o  (dbg_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] mk(input int op, input int sel, input int en, input int we,
                                       input int vop, input int a, input int b, input int d);
        mk = {op[1:0], sel[0], en[0], we[0], vop[0], a[4:0], b[4:0], d[4:0]};
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_raddr_i = i[4:0];
            #1 check(tag, dbg_rdata_o, model[i]);
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
        dbg_raddr_i = idx[4:0];
        #1 check(tag, dbg_rdata_o, exp);
    endtask

    // Drives one word and follows it to completion, predicting every output from the model.
    task automatic run_word(input logic [20:0] w, input int ack_delay, input logic [31:0] rdata);
        logic [1:0]  op;
        logic        en, we, vop;
        logic [4:0]  dst;
        logic [31:0] a, b, res;
        op  = w[20:19];
        en  = w[17];
        we  = w[16];
        vop = w[15];
        dst = w[4:0];
        a   = model[w[14:10]];
        b   = model[w[9:5]];
        case (op)
            2'd0:    res = a & b;
            2'd1:    res = a | b;
            2'd2:    res = a + b;
            default: res = a - b;
        endcase

        @(negedge clk);
        ctrl_i       = w;
        ctrl_valid_i = 1'b1;
        #1 check("accept_ready", ctrl_ready_o, 1);
        @(negedge clk);
        ctrl_valid_i = 1'b0;
        ctrl_i       = 21'($urandom);
        #1;
        check("exec_ready", ctrl_ready_o, 0);
        check("exec_retire", retire_o, (!vop || !en));
        check("exec_req", dmem_req_o, 0);
        check("exec_err", err_o, 0);
        if (vop && !en && dst != 0) model[dst] = res;

        if (vop && en) begin
            for (int k = 0; k < ack_delay; k++) begin
                @(negedge clk);
                if (k == ack_delay - 1) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = rdata;
                end
                #1;
                check("mem_req", dmem_req_o, 1);
                check("mem_addr", dmem_addr_o, res[15:0]);
                check("mem_we", dmem_we_o, we);
                if (we) check("mem_wdata", dmem_wdata_o, model[dst]);
                check("mem_retire", retire_o, (k == ack_delay - 1));
                check("mem_err", err_o, 0);
            end
            @(negedge clk);
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = $urandom;
            if (!we && dst != 0) model[dst] = rdata;
        end else begin
            @(negedge clk);
        end
        #1;
        check("post_ready", ctrl_ready_o, 1);
        check("post_req", dmem_req_o, 0);
        check("post_retire", retire_o, 0);
        check_reg("post_dst", dst, model[dst]);
    endtask

    initial begin
        rst_n        = 1'b0;
        ctrl_i       = '0;
        ctrl_valid_i = 1'b0;
        dmem_rdata_i = '0;
        dmem_ack_i   = 1'b0;
        dbg_raddr_i  = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        rst_n       = 1'b1;
        dbg_raddr_i = 5'd5;
        #1;
        check("rst_dbg5", dbg_rdata_o, 0);
        check("rst_ready", ctrl_ready_o, 1);
        check("rst_req", dmem_req_o, 0);
        check("rst_retire", retire_o, 0);
        check("rst_err", err_o, 0);
        check("rst_addr", dmem_addr_o, 0);

        run_word(mk(2, 1, 1, 0, 1, 0, 0, 3), 3, 32'h7);
        check_reg("load_r3", 3, 32'h7);
        run_word(mk(2, 0, 0, 0, 1, 3, 3, 4), 0, 0);
        check_reg("add_r4", 4, 32'd14);
        run_word(mk(3, 0, 0, 0, 1, 3, 4, 5), 0, 0);
        check_reg("sub_r5", 5, 32'hFFFF_FFF9);
        run_word(mk(0, 0, 0, 0, 1, 3, 4, 6), 0, 0);
        check_reg("and_r6", 6, 32'd6);
        run_word(mk(1, 0, 0, 0, 1, 3, 4, 7), 0, 0);
        check_reg("or_r7", 7, 32'd15);
        run_word(mk(2, 1, 1, 1, 1, 3, 0, 4), 2, 32'hBAD0_BAD0);
        check_all_regs("store_regs");
        run_word(mk(2, 0, 0, 0, 1, 3, 4, 0), 0, 0);
        check_reg("r0_zero", 0, 32'h0);
        run_word(21'b0, 0, 0);
        check_all_regs("nop_regs");

        @(negedge clk);
        dmem_ack_i = 1'b1;
        #1;
        check("idle_ack_retire", retire_o, 0);
        check("idle_ack_req", dmem_req_o, 0);
        @(negedge clk);
        dmem_ack_i = 1'b0;
        #1 check("idle_ack_ready", ctrl_ready_o, 1);
        check_all_regs("idle_ack_regs");

        for (int n = 0; n < 40; n++) begin
            int en;
            en = ($urandom_range(0, 2) == 0) ? 1 : 0;
            run_word(mk($urandom_range(0, 3), $urandom_range(0, 1), en, $urandom_range(0, 1),
                        ($urandom_range(0, 7) != 0) ? 1 : 0, $urandom_range(0, 31),
                        $urandom_range(0, 31), $urandom_range(0, 31)),
                     $urandom_range(1, 4), $urandom);
        end
        check_all_regs("rand_regs");

`ifdef CTRL_EXEC_TIMEOUT_EN
        @(negedge clk);
        ctrl_i       = mk(2, 0, 1, 0, 1, 0, 0, 9);
        ctrl_valid_i = 1'b1;
        @(negedge clk);
        ctrl_valid_i = 1'b0;
        dmem_rdata_i = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("to_req", dmem_req_o, 1);
            check("to_err", err_o, (k == 3));
            check("to_retire", retire_o, (k == 3));
        end
        @(negedge clk);
        #1;
        check("to_post_req", dmem_req_o, 0);
        check("to_post_ready", ctrl_ready_o, 1);
        check("to_post_err", err_o, 0);
        check_all_regs("to_regs");
`else
        run_word(mk(2, 0, 1, 0, 1, 0, 0, 9), 10, 32'h1234_5678);
`endif

        @(negedge clk);
        ctrl_i       = mk(2, 0, 1, 0, 1, 3, 0, 9);
        ctrl_valid_i = 1'b1;
        @(negedge clk);
        ctrl_valid_i = 1'b0;
        @(negedge clk);
        #1 check("rstmem_req_before", dmem_req_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rstmem_req", dmem_req_o, 0);
        check("rstmem_ready", ctrl_ready_o, 1);
        check("rstmem_retire", retire_o, 0);
        rst_n        = 1'b1;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hCAFE_F00D;
        #1 check("late_ack_retire", retire_o, 0);
        @(negedge clk);
        dmem_ack_i = 1'b0;
        #1 check("late_ack_req", dmem_req_o, 0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        check_all_regs("rstmem_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
